// File: rtl/logic_op_pkg.sv
// Shared types for the logic_op_pipe streaming logic unit.
package logic_op_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  // Control half of the stage-1 payload; operands stay WIDTH-parametrised in the pipe.
  typedef struct packed {
    op_e  op;
    logic acc;
  } s1_ctrl_t;

endpackage

// File: rtl/logic_op_pipe_if.sv
// Operand/result stream bundle for logic_op_pipe; master drives operands, slave is the unit.
interface logic_op_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
);
  import logic_op_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  op_e              in_op;
  logic             in_acc;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_a, in_b, in_op, in_acc, acc_clr, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_acc, acc_clr, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_count
  );

endinterface

// File: rtl/logic_op_core.sv
// Combinational bitwise operator: res = op(a, b), no carries between bits.
module logic_op_core
  import logic_op_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  op_e              op_i,
  output logic [WIDTH-1:0] res_o
);

  always_comb begin
    res_o = '0;
    unique case (op_i)
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      OP_NAND: res_o = ~(a_i & b_i);
    endcase
  end

endmodule

// File: rtl/logic_op_pipe.sv
// Two-stage valid/ready bitwise logic unit with accumulate mode and delivered-result counter.
module logic_op_pipe
  import logic_op_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input logic            clk,
  input logic            rst,
  logic_op_pipe_if.slave bus
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  s1_ctrl_t         s1_ctrl_q, s1_ctrl_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s2_free_c;
  logic             s1_adv_c;
  logic             in_ready_c;
  logic             accept_c;
  logic [WIDTH-1:0] core_b_c;
  logic [WIDTH-1:0] core_res_c;

  // Handshake: S1 may refill in the same cycle it drains, giving one beat per clock.
  always_comb begin
    s2_free_c  = !s2_valid_q || bus.out_ready;
    s1_adv_c   = s1_valid_q && s2_free_c;
    in_ready_c = !s1_valid_q || s2_free_c;
    accept_c   = bus.in_valid && in_ready_c;
    core_b_c   = s1_ctrl_q.acc ? acc_q : s1_b_q;
  end

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .a_i   (s1_a_q),
    .b_i   (core_b_c),
    .op_i  (s1_ctrl_q.op),
    .res_o (core_res_c)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_ctrl_d  = s1_ctrl_q;
    s2_valid_d = s2_valid_q;
    res_d      = res_q;
    zero_d     = zero_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;

    if (accept_c) begin
      s1_valid_d    = 1'b1;
      s1_a_d        = bus.in_a;
      s1_b_d        = bus.in_b;
      s1_ctrl_d.op  = bus.in_op;
      s1_ctrl_d.acc = bus.in_acc;
    end else if (s1_adv_c) begin
      s1_valid_d = 1'b0;
    end

    // Result registers only move on advance, so they hold while S2 is stalled.
    if (s1_adv_c) begin
      s2_valid_d = 1'b1;
      res_d      = core_res_c;
      zero_d     = (core_res_c == '0);
    end else if (bus.out_ready) begin
      s2_valid_d = 1'b0;
    end

    // Clear beats the advance update; the advancing beat already consumed the old acc.
    if (bus.acc_clr) begin
      acc_d = '0;
    end else if (s1_adv_c) begin
      acc_d = core_res_c;
    end

    if (s2_valid_q && bus.out_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_ctrl_q  <= '{op: OP_AND, acc: 1'b0};
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      zero_q     <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_ctrl_q  <= s1_ctrl_d;
      s2_valid_q <= s2_valid_d;
      res_q      <= res_d;
      zero_q     <= zero_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = s2_valid_q;
  assign bus.out_result = res_q;
  assign bus.out_zero   = zero_q;
  assign bus.out_count  = cnt_q;

endmodule

// File: tb/tb_logic_op_pipe.sv
// Self-checking bench for logic_op_pipe: directed scenarios plus randomized traffic vs. a beat-order model.
module tb_logic_op_pipe;
  import logic_op_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic_op_pipe_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  logic_op_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc   = 0;
  bit         last_acc;
  bit         last_dlv;
  bit         track = 1'b1;
  logic [7:0] model_acc;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       gotz_q[$];
  int         gotc_q[$];

  function automatic logic [7:0] ref_op(logic [1:0] op, logic [7:0] a, logic [7:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  // One clock: observe handshakes, feed the beat-order model, then step past the edge.
  task automatic tick();
    logic [7:0] bb;
    #1;
    last_acc = bus.in_valid && bus.in_ready;
    last_dlv = bus.out_valid && bus.out_ready;
    if (bus.acc_clr) model_acc = '0;
    if (last_acc) begin
      bb = bus.in_acc ? model_acc : bus.in_b;
      model_acc = ref_op(bus.in_op, bus.in_a, bb);
      if (track) exp_q.push_back(model_acc);
    end
    if (last_dlv && track) begin
      got_q.push_back(bus.out_result);
      gotz_q.push_back(bus.out_zero);
      gotc_q.push_back(cyc);
    end
    if (rst) model_acc = '0;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_op    = OP_AND;
    bus.in_acc   = 1'b0;
    bus.acc_clr  = 1'b0;
  endtask

  task automatic clear_q();
    exp_q.delete();
    got_q.delete();
    gotz_q.delete();
    gotc_q.delete();
  endtask

  task automatic do_reset();
    idle_inputs();
    bus.out_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clear_q();
  endtask

  task automatic send_beat(logic [7:0] a, logic [7:0] b, op_e op, logic acc);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
    bus.in_acc   = acc;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    n_vec++;
    if (bus.out_count !== 16'h0000) begin
      n_err++; $display("FAIL reset_out_count: got %h want 0000", bus.out_count);
    end
    n_vec++;
    if (bus.out_result !== 8'h00 || bus.out_zero !== 1'b0) begin
      n_err++; $display("FAIL reset_result: got %h/%b want 00/0", bus.out_result, bus.out_zero);
    end
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_ops();
    logic [7:0] ta [5] = '{8'h14, 8'h94, 8'hF0, 8'hFF, 8'h00};
    logic [7:0] tb [5] = '{8'h1E, 8'h1E, 8'h3C, 8'hAA, 8'h00};
    op_e        to [5] = '{OP_AND, OP_OR, OP_XOR, OP_NAND, OP_AND};
    logic [7:0] te [5] = '{8'h14, 8'h9E, 8'hCC, 8'h55, 8'h00};
    logic       tz [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_beat(ta[i], tb[i], to[i], 1'b0);
      n_vec++;
      if (bus.out_valid !== 1'b0) begin
        n_err++; $display("FAIL ops_early[%0d]: out_valid %b one edge after accept, want 0", i, bus.out_valid);
      end
      tick();
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== te[i] || bus.out_zero !== tz[i]) begin
        n_err++;
        $display("FAIL ops[%0d]: valid=%b result=%h zero=%b, want 1 %h %b",
                 i, bus.out_valid, bus.out_result, bus.out_zero, te[i], tz[i]);
      end
      tick();
    end
  endtask

  task automatic test_acc_chain();
    logic [7:0] want [3] = '{8'h01, 8'h03, 8'h07};
    do_reset();
    bus.acc_clr = 1'b1;
    tick();
    bus.acc_clr = 1'b0;
    clear_q();
    for (int i = 0; i < 3; i++) begin
      bus.in_a     = 8'(1 << i);
      bus.in_b     = 8'($urandom);
      bus.in_op    = OP_OR;
      bus.in_acc   = 1'b1;
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 10 && got_q.size() < 3; k++) tick();
    n_vec++;
    if (got_q.size() != 3) begin
      n_err++; $display("FAIL acc_chain_count: got %0d results want 3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (got_q[i] !== want[i]) begin
          n_err++; $display("FAIL acc_chain[%0d]: got %h want %h", i, got_q[i], want[i]);
        end
      end
      n_vec++;
      if (gotc_q[1] != gotc_q[0] + 1 || gotc_q[2] != gotc_q[1] + 1) begin
        n_err++;
        $display("FAIL acc_chain_spacing: cycles %0d %0d %0d want consecutive", gotc_q[0], gotc_q[1], gotc_q[2]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] ba [4];
    logic [7:0] bb [4];
    op_e        bo [4];
    int         idx = 0;
    logic [7:0] held = '0;
    bit         have = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ba[i] = 8'($urandom);
      bb[i] = 8'($urandom);
      bo[i] = op_e'($urandom_range(0, 3));
    end
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (idx < 4) begin
        bus.in_a = ba[idx]; bus.in_b = bb[idx]; bus.in_op = bo[idx]; bus.in_valid = 1'b1;
      end
      tick();
      if (last_acc) idx++;
      if (bus.out_valid) begin
        if (!have) begin
          held = bus.out_result; have = 1'b1;
        end else begin
          n_vec++;
          if (bus.out_result !== held) begin
            n_err++; $display("FAIL bp_hold: result %h changed under stall, want %h", bus.out_result, held);
          end
        end
      end
    end
    n_vec++;
    if (idx != 2 || bus.in_ready !== 1'b0) begin
      n_err++; $display("FAIL bp_stall: accepts=%0d in_ready=%b want 2 and 0", idx, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20 && got_q.size() < 4; k++) begin
      if (idx < 4) begin
        bus.in_a = ba[idx]; bus.in_b = bb[idx]; bus.in_op = bo[idx]; bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      if (last_acc) idx++;
    end
    bus.in_valid = 1'b0;
    tick();
    n_vec++;
    if (got_q.size() != 4) begin
      n_err++; $display("FAIL bp_delivered: got %0d results want 4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (got_q[i] !== ref_op(bo[i], ba[i], bb[i])) begin
          n_err++; $display("FAIL bp_order[%0d]: got %h want %h", i, got_q[i], ref_op(bo[i], ba[i], bb[i]));
        end
      end
    end
    n_vec++;
    if (bus.out_count !== 16'd4) begin
      n_err++; $display("FAIL bp_count: got %0d want 4", bus.out_count);
    end
  endtask

  task automatic test_clr_collision();
    do_reset();
    bus.acc_clr = 1'b1;
    tick();
    bus.acc_clr = 1'b0;
    send_beat(8'h01, 8'hFF, OP_OR, 1'b1);
    send_beat(8'h02, 8'hFF, OP_OR, 1'b1);
    send_beat(8'h04, 8'hFF, OP_OR, 1'b1);
    tick();
    tick();
    send_beat(8'h10, 8'hFF, OP_OR, 1'b1);
    bus.acc_clr = 1'b1;
    tick();
    bus.acc_clr = 1'b0;
    tick();
    send_beat(8'h0F, 8'hFF, OP_XOR, 1'b1);
    for (int k = 0; k < 10 && got_q.size() < 5; k++) tick();
    n_vec++;
    if (got_q.size() != 5) begin
      n_err++; $display("FAIL clr_count: got %0d results want 5", got_q.size());
    end else begin
      n_vec++;
      if (got_q[2] !== 8'h07) begin
        n_err++; $display("FAIL clr_pre: got %h want 07", got_q[2]);
      end
      n_vec++;
      if (got_q[3] !== 8'h17) begin
        n_err++; $display("FAIL clr_same_cycle: got %h want 17", got_q[3]);
      end
      n_vec++;
      if (got_q[4] !== 8'h0F) begin
        n_err++; $display("FAIL clr_after: got %h want 0f", got_q[4]);
      end
    end
  endtask

  task automatic test_reset_inflight();
    int acc_n = 0;
    do_reset();
    send_beat(8'h3C, 8'h00, OP_XOR, 1'b1);
    tick();
    tick();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 6 && acc_n < 2; k++) begin
      bus.in_a = 8'($urandom); bus.in_b = 8'($urandom); bus.in_op = OP_OR;
      bus.in_acc = 1'b1; bus.in_valid = 1'b1;
      tick();
      if (last_acc) acc_n++;
    end
    n_vec++;
    if (acc_n != 2 || bus.in_ready !== 1'b0 || bus.out_count !== 16'd1) begin
      n_err++;
      $display("FAIL inflight_setup: accepts=%0d in_ready=%b count=%0d want 2 0 1", acc_n, bus.in_ready, bus.out_count);
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.out_count !== 16'd0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL inflight_reset: valid=%b count=%0d in_ready=%b want 0 0 1", bus.out_valid, bus.out_count, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    clear_q();
    for (int k = 0; k < 5; k++) tick();
    n_vec++;
    if (got_q.size() != 0) begin
      n_err++; $display("FAIL inflight_ghost: %0d held beats emerged, want 0", got_q.size());
    end
    send_beat(8'h5A, 8'hFF, OP_XOR, 1'b1);
    for (int k = 0; k < 5 && got_q.size() < 1; k++) tick();
    n_vec++;
    if (got_q.size() != 1 || got_q[0] !== 8'h5A) begin
      n_err++; $display("FAIL inflight_acc: got %0d results first=%h want 1 result 5a", got_q.size(), got_q.size() > 0 ? got_q[0] : 8'hxx);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_a      = 8'($urandom);
      bus.in_b      = 8'($urandom);
      bus.in_op     = op_e'($urandom_range(0, 3));
      bus.in_acc    = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.acc_clr   = (exp_q.size() == got_q.size()) && ($urandom_range(0, 5) == 0);
      tick();
    end
    idle_inputs();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20 && got_q.size() < exp_q.size(); k++) tick();
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL rand_count: got %0d results want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_vec++;
        if (got_q[i] !== exp_q[i] || gotz_q[i] !== (exp_q[i] == 8'h00)) begin
          n_err++;
          $display("FAIL rand[%0d]: got %h/%b want %h/%b", i, got_q[i], gotz_q[i], exp_q[i], exp_q[i] == 8'h00);
        end
      end
    end
    n_vec++;
    if (bus.out_count !== 16'(got_q.size())) begin
      n_err++; $display("FAIL rand_out_count: got %0d want %0d", bus.out_count, got_q.size());
    end
  endtask

  task automatic test_count_wrap();
    int dlv = 0;
    do_reset();
    track = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = 8'hA5;
    bus.in_b      = 8'h0F;
    for (int k = 0; k < 70000 && dlv < 65535; k++) begin
      tick();
      if (last_dlv) dlv++;
    end
    n_vec++;
    if (dlv != 65535 || bus.out_count !== 16'hFFFF) begin
      n_err++; $display("FAIL count_preload: delivered=%0d count=%h want 65535 ffff", dlv, bus.out_count);
    end
    for (int k = 0; k < 5 && dlv < 65536; k++) begin
      tick();
      if (last_dlv) dlv++;
    end
    n_vec++;
    if (dlv != 65536 || bus.out_count !== 16'h0000) begin
      n_err++; $display("FAIL count_wrap: delivered=%0d count=%h want 65536 0000", dlv, bus.out_count);
    end
    bus.in_valid = 1'b0;
    track = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    model_acc = '0;
    idle_inputs();
    bus.out_ready = 1'b1;
    test_reset();
    test_ops();
    test_acc_chain();
    test_backpressure();
    test_clr_collision();
    test_reset_inflight();
    test_random();
    test_count_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
